// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage: ALU operation codes,
// RV32I opcodes, branch kinds and operand-select encodings.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU
  } br_type_e;

  typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_e;
  typedef enum logic [1:0] {B_RS2, B_IMM, B_ZERO} b_sel_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Register and immediate arithmetic share one funct3 map; only the
  // ADD/SUB and SRL/SRA alternates differ between OP and OP-IMM.
  function automatic alu_op_e arith_op(input logic [2:0] funct3,
                                       input logic alt_sub,
                                       input logic alt_sra);
    case (funct3)
      3'b000:  arith_op = alt_sub ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = alt_sra ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction

  function automatic logic br_resolve(input br_type_e br_type,
                                      input logic zero,
                                      input logic lsb);
    case (br_type)
      BR_EQ:          br_resolve = zero;
      BR_NE:          br_resolve = !zero;
      BR_LT, BR_LTU:  br_resolve = lsb;
      BR_GE, BR_GEU:  br_resolve = !lsb;
      default:        br_resolve = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_encode.sv
// Combinational decode of opcode/funct3/funct7_5 into ALU operation,
// operand selects, branch kind and an illegal-instruction flag.
module alu_op_encode
  import alu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output alu_op_e    alu_op,
  output a_sel_e     a_sel,
  output b_sel_e     b_sel,
  output br_type_e   br_type,
  output logic       illegal
);

  always_comb begin
    alu_op  = ALU_ADD;
    a_sel   = A_ZERO;
    b_sel   = B_ZERO;
    br_type = BR_NONE;
    illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        a_sel  = A_RS1;
        b_sel  = B_RS2;
        alu_op = arith_op(funct3, funct7_5, funct7_5);
      end
      // Immediate forms never subtract; bit 30 only picks SRAI.
      OPC_OP_IMM: begin
        a_sel  = A_RS1;
        b_sel  = B_IMM;
        alu_op = arith_op(funct3, 1'b0, funct7_5);
      end
      OPC_LOAD, OPC_STORE, OPC_JALR: begin
        a_sel = A_RS1;
        b_sel = B_IMM;
      end
      OPC_LUI: begin
        b_sel = B_IMM;
      end
      OPC_AUIPC: begin
        a_sel = A_PC;
        b_sel = B_IMM;
      end
      OPC_BRANCH: begin
        a_sel = A_RS1;
        b_sel = B_RS2;
        case (funct3)
          F3_BEQ:  begin alu_op = ALU_SUB;  br_type = BR_EQ;  end
          F3_BNE:  begin alu_op = ALU_SUB;  br_type = BR_NE;  end
          F3_BLT:  begin alu_op = ALU_SLT;  br_type = BR_LT;  end
          F3_BGE:  begin alu_op = ALU_SLT;  br_type = BR_GE;  end
          F3_BLTU: begin alu_op = ALU_SLTU; br_type = BR_LTU; end
          F3_BGEU: begin alu_op = ALU_SLTU; br_type = BR_GEU; end
          default: begin
            a_sel   = A_ZERO;
            b_sel   = B_ZERO;
            illegal = 1'b1;
          end
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// One-entry ALU issue stage: encodes and registers operands/control for a
// combinational ALU, returns its result and resolves branches.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7_5,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_pc,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic             out_br_taken,
  output logic             out_illegal,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {ST_EMPTY, ST_FULL} state_e;

  state_e    state;
  alu_op_e   ctrl_q;
  br_type_e  br_q;
  logic      illegal_q;

  alu_op_e   dec_op;
  a_sel_e    dec_a_sel;
  b_sel_e    dec_b_sel;
  br_type_e  dec_br;
  logic      dec_illegal;
  logic [XLEN-1:0] a_next;
  logic [XLEN-1:0] b_next;
  logic      full;
  logic      accept;

  alu_op_encode u_encode (
    .opcode   (in_opcode),
    .funct3   (in_funct3),
    .funct7_5 (in_funct7_5),
    .alu_op   (dec_op),
    .a_sel    (dec_a_sel),
    .b_sel    (dec_b_sel),
    .br_type  (dec_br),
    .illegal  (dec_illegal)
  );

  always_comb begin
    case (dec_a_sel)
      A_RS1:   a_next = in_rs1;
      A_PC:    a_next = in_pc;
      default: a_next = '0;
    endcase
    case (dec_b_sel)
      B_RS2:   b_next = in_rs2;
      B_IMM:   b_next = in_imm;
      default: b_next = '0;
    endcase
  end

  assign full     = (state == ST_FULL);
  assign in_ready = !full || out_ready;
  assign accept   = in_valid && in_ready;

  // A new accept while FULL replaces the retiring entry in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_EMPTY;
      alu_a       <= '0;
      alu_b       <= '0;
      ctrl_q      <= ALU_ADD;
      br_q        <= BR_NONE;
      illegal_q   <= 1'b0;
      op_count    <= '0;
      stall_count <= '0;
    end else begin
      if (accept) begin
        state     <= ST_FULL;
        alu_a     <= a_next;
        alu_b     <= b_next;
        ctrl_q    <= dec_op;
        br_q      <= dec_br;
        illegal_q <= dec_illegal;
      end else if (full && out_ready) begin
        state <= ST_EMPTY;
      end
      if (full) begin
        if (out_ready) op_count    <= op_count + CNT_W'(1);
        else           stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

  assign alu_ctrl     = ctrl_q;
  assign out_valid    = full;
  assign out_result   = full ? alu_result : '0;
  assign out_illegal  = full && illegal_q;
  assign out_br_taken = full && br_resolve(br_q, alu_zero, alu_result[0]);

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed cases followed by random
// traffic scored against an instruction-level reference model.
module tb_alu_issue_stage;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam int NRAND = 400;

  typedef struct packed {
    logic [31:0] result;
    logic        taken;
    logic        illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_funct7_5;
  logic [31:0] in_rs1, in_rs2, in_imm, in_pc;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_zero;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_br_taken, out_illegal;
  logic [31:0] op_count, stall_count;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  logic [6:0] opc_list [10] = '{OP, OPIMM, LOAD, STORE, JALR, LUI, AUIPC, BRANCH, BRANCH, 7'h7F};

  always #5 clk = !clk;

  alu_issue_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_br_taken(out_br_taken), .out_illegal(out_illegal),
    .op_count(op_count), .stall_count(stall_count)
  );

  // Combinational ALU driven by the stage.
  always_comb begin
    case (alu_ctrl)
      4'd0:    alu_result = alu_a + alu_b;
      4'd1:    alu_result = alu_a - alu_b;
      4'd2:    alu_result = alu_a & alu_b;
      4'd3:    alu_result = alu_a | alu_b;
      4'd4:    alu_result = alu_a ^ alu_b;
      4'd5:    alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      4'd6:    alu_result = {31'b0, alu_a < alu_b};
      4'd7:    alu_result = alu_a << alu_b[4:0];
      4'd8:    alu_result = alu_a >> alu_b[4:0];
      4'd9:    alu_result = $signed(alu_a) >>> alu_b[4:0];
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == 32'd0);

  // Instruction-level expectation straight from the RV32I semantics.
  function automatic exp_t refModel(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                    input logic [31:0] rs1, input logic [31:0] rs2,
                                    input logic [31:0] imm, input logic [31:0] pc);
    exp_t e;
    logic [31:0] x;
    logic lt, ltu;
    e = '0;
    if (opc == OP) x = rs2; else x = imm;
    case (opc)
      OP, OPIMM: begin
        case (f3)
          3'd0: e.result = (opc == OP && f7) ? rs1 - x : rs1 + x;
          3'd1: e.result = rs1 << x[4:0];
          3'd2: e.result = {31'b0, $signed(rs1) < $signed(x)};
          3'd3: e.result = {31'b0, rs1 < x};
          3'd4: e.result = rs1 ^ x;
          3'd5: e.result = f7 ? 32'($signed(rs1) >>> x[4:0]) : rs1 >> x[4:0];
          3'd6: e.result = rs1 | x;
          default: e.result = rs1 & x;
        endcase
      end
      LOAD, STORE, JALR: e.result = rs1 + imm;
      LUI:   e.result = imm;
      AUIPC: e.result = pc + imm;
      BRANCH: begin
        lt  = $signed(rs1) < $signed(rs2);
        ltu = rs1 < rs2;
        case (f3)
          3'd0: begin e.result = rs1 - rs2;    e.taken = (rs1 == rs2); end
          3'd1: begin e.result = rs1 - rs2;    e.taken = (rs1 != rs2); end
          3'd4: begin e.result = {31'b0, lt};  e.taken = lt;   end
          3'd5: begin e.result = {31'b0, lt};  e.taken = !lt;  end
          3'd6: begin e.result = {31'b0, ltu}; e.taken = ltu;  end
          3'd7: begin e.result = {31'b0, ltu}; e.taken = !ltu; end
          default: e.illegal = 1'b1;
        endcase
      end
      default: e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Present one instruction at a negedge; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [31:0] imm, input logic [31:0] pc);
    @(negedge clk);
    in_opcode = opc; in_funct3 = f3; in_funct7_5 = f7;
    in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_pc = pc;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic checkHeld(input string tag, input exp_t e);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_result"}, out_result, e.result);
    checkOutput({tag, "_taken"}, 32'(out_br_taken), 32'(e.taken));
    checkOutput({tag, "_illegal"}, 32'(out_illegal), 32'(e.illegal));
  endtask

  initial begin
    exp_t e;
    int ref_ops, ref_stalls;
    logic v, r;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_opcode = '0; in_funct3 = '0; in_funct7_5 = 1'b0;
    in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_pc = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    checkOutput("rst_alu_a", alu_a, 32'd0);
    checkOutput("rst_op_count", op_count, 32'd0);
    checkOutput("rst_stall_count", stall_count, 32'd0);

    applyStimulus(OP, 3'd0, 1'b1, 32'd9, 32'd4, 32'd0, 32'd0);
    checkOutput("sub_ctrl", 32'(alu_ctrl), 32'b0001);
    checkHeld("sub", '{result: 32'd5, taken: 1'b0, illegal: 1'b0});

    applyStimulus(OPIMM, 3'd5, 1'b1, 32'h8000_0000, 32'd0, 32'd4, 32'd0);
    checkOutput("srai_ctrl", 32'(alu_ctrl), 32'b1001);
    checkHeld("srai", '{result: 32'hF800_0000, taken: 1'b0, illegal: 1'b0});

    applyStimulus(BRANCH, 3'd4, 1'b0, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'd0);
    checkOutput("blt_taken", 32'(out_br_taken), 32'd1);
    applyStimulus(BRANCH, 3'd0, 1'b0, 32'd3, 32'd3, 32'd0, 32'd0);
    checkOutput("beq_taken", 32'(out_br_taken), 32'd1);
    applyStimulus(BRANCH, 3'd1, 1'b0, 32'd3, 32'd3, 32'd0, 32'd0);
    checkOutput("bne_taken", 32'(out_br_taken), 32'd0);

    applyStimulus(7'h7F, 3'd0, 1'b0, 32'd7, 32'd8, 32'd9, 32'd10);
    checkHeld("illegal", '{result: 32'd0, taken: 1'b0, illegal: 1'b1});
    applyStimulus(AUIPC, 3'd0, 1'b0, 32'd0, 32'd0, 32'h1000, 32'h100);
    checkHeld("auipc", '{result: 32'h1100, taken: 1'b0, illegal: 1'b0});

    // Three-cycle downstream stall starting from clean counters.
    pulseReset();
    out_ready = 1'b1;
    applyStimulus(OP, 3'd6, 1'b0, 32'h00F0, 32'h0F00, 32'd0, 32'd0);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checkOutput("stall_result", out_result, 32'h0FF0);
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
    end
    checkOutput("stall_count", stall_count, 32'd3);
    checkOutput("stall_op_count", op_count, 32'd0);

    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_opcode = OP; in_funct3 = 3'd0; in_funct7_5 = 1'b0;
      in_rs1 = 32'(k); in_rs2 = 32'd10;
      in_valid = 1'b1;
      #1;
      checkOutput("b2b_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      checkOutput("b2b_op_count", op_count, 32'(k + 1));
      checkOutput("b2b_result", out_result, 32'(k + 10));
    end
    in_valid = 1'b0;

    // Reset lands while an op is held and stalled.
    applyStimulus(OP, 3'd0, 1'b1, 32'd20, 32'd1, 32'd0, 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_op_count", op_count, 32'd0);
    checkOutput("midrst_stall_count", stall_count, 32'd0);
    checkOutput("midrst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    ref_ops = 0;
    ref_stalls = 0;
    for (int i = 0; i < NRAND + 4; i++) begin
      @(negedge clk);
      v = (i < NRAND) ? ($urandom_range(0, 9) < 7) : 1'b0;
      r = (i < NRAND) ? ($urandom_range(0, 9) < 6) : 1'b1;
      in_valid = v;
      out_ready = r;
      in_opcode = opc_list[$urandom_range(0, 9)];
      in_funct3 = 3'($urandom_range(0, 7));
      in_funct7_5 = 1'($urandom_range(0, 1));
      in_rs1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
      in_rs2 = ($urandom_range(0, 3) == 0) ? in_rs1 : $urandom;
      in_imm = $urandom;
      in_pc = $urandom;
      #1;
      checkOutput("rnd_out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      checkOutput("rnd_in_ready", 32'(in_ready), 32'(exp_q.size() == 0 || r));
      if (exp_q.size() != 0) begin
        checkHeld("rnd", exp_q[0]);
        if (r) begin
          void'(exp_q.pop_front());
          ref_ops++;
        end else begin
          ref_stalls++;
        end
      end
      if (v && (exp_q.size() == 0)) begin
        e = refModel(in_opcode, in_funct3, in_funct7_5, in_rs1, in_rs2, in_imm, in_pc);
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
    #1;
    checkOutput("rnd_drained", 32'(out_valid), 32'd0);
    checkOutput("rnd_op_count", op_count, 32'(ref_ops));
    checkOutput("rnd_stall_count", stall_count, 32'(ref_stalls));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
